// File: rtl/dmem_bridge.sv
// Data-side bridge between the core's M stage and a req/addr_ok/data_ok SRAM-like bus.
// Define DMEM_BRIDGE_STATS_EN to add the load/store/wait statistics counters.
module dmem_bridge #(
   parameter int unsigned TIMEOUT_CYCLES = 255,
   parameter int unsigned CNT_W          = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        mem_en,
   input  logic        memwrite,
   input  logic [1:0]  mem_size,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   input  logic        stall_other,
   output logic [31:0] rdata,
   output logic        stall,
   output logic        err,
   output logic        data_req,
   output logic        data_wr,
   output logic [1:0]  data_size,
   output logic [31:0] data_addr,
   output logic [31:0] data_wdata,
   input  logic        data_addr_ok,
   input  logic        data_data_ok,
   input  logic [31:0] data_rdata
`ifdef DMEM_BRIDGE_STATS_EN
   ,
   output logic [31:0] cnt_load,
   output logic [31:0] cnt_store,
   output logic [31:0] cnt_wait
`endif
);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_REQ,
      ST_WAIT,
      ST_DONE
   } state_t;

   state_t state_reg, state_next;

   logic [CNT_W-1:0] wait_cnt_reg;
   logic [CNT_W-1:0] wait_cnt_inc;
   logic             timeout_hit;
   logic             issue;
   logic             accept;
   logic             complete;
   logic             abort;

   assign wait_cnt_inc = wait_cnt_reg + CNT_W'(1);
   // A zero TIMEOUT_CYCLES means wait forever for data_ok.
   assign timeout_hit  = (TIMEOUT_CYCLES != 0) && (wait_cnt_inc == CNT_W'(TIMEOUT_CYCLES));

   assign stall = ((state_reg == ST_IDLE) && mem_en) ||
                  (state_reg == ST_REQ) || (state_reg == ST_WAIT);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg <= ST_IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      issue      = 1'b0;
      accept     = 1'b0;
      complete   = 1'b0;
      abort      = 1'b0;
      case (state_reg)
         ST_IDLE: begin
            if (mem_en) begin
               issue      = 1'b1;
               state_next = ST_REQ;
            end
         end
         ST_REQ: begin
            if (data_addr_ok) begin
               accept = 1'b1;
               if (data_data_ok) begin
                  complete   = 1'b1;
                  state_next = ST_DONE;
               end else begin
                  state_next = ST_WAIT;
               end
            end
         end
         ST_WAIT: begin
            if (data_data_ok) begin
               complete   = 1'b1;
               state_next = ST_DONE;
            end else if (timeout_hit) begin
               abort      = 1'b1;
               state_next = ST_DONE;
            end
         end
         ST_DONE: begin
            // The core still presents the same access while stalled elsewhere.
            if (!stall_other) begin
               state_next = ST_IDLE;
            end
         end
         default: state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         data_req     <= 1'b0;
         data_wr      <= 1'b0;
         data_size    <= 2'd0;
         data_addr    <= 32'd0;
         data_wdata   <= 32'd0;
         rdata        <= 32'd0;
         err          <= 1'b0;
         wait_cnt_reg <= '0;
      end else begin
         err <= abort;
         if (issue) begin
            data_req   <= 1'b1;
            data_wr    <= memwrite;
            data_size  <= mem_size;
            data_addr  <= addr;
            data_wdata <= wdata;
         end else if (accept) begin
            data_req <= 1'b0;
         end
         if (accept) begin
            wait_cnt_reg <= '0;
         end else if (state_reg == ST_WAIT) begin
            wait_cnt_reg <= wait_cnt_inc;
         end
         if (complete && !data_wr) begin
            rdata <= data_rdata;
         end else if (abort) begin
            rdata <= 32'd0;
         end
      end
   end

`ifdef DMEM_BRIDGE_STATS_EN
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_load  <= 32'd0;
         cnt_store <= 32'd0;
         cnt_wait  <= 32'd0;
      end else begin
         if (stall) begin
            cnt_wait <= cnt_wait + 32'd1;
         end
         if (complete) begin
            if (data_wr) begin
               cnt_store <= cnt_store + 32'd1;
            end else begin
               cnt_load <= cnt_load + 32'd1;
            end
         end
      end
   end
`endif

endmodule
